// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives instruction-memory addresses,
// captures 1-cycle-latency read data into a 2-entry buffer and presents it
// to the control unit over valid/ready. Handles jump redirects and endop halt.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 pulse: (re)start fetching at START_ADDR from IDLE/HALT
//   mem_addr / mem_data   instruction memory address out / read data in (1-cycle latency)
//   instr, instr_pc       buffer head instruction and the address it came from
//   instr_valid           buffer non-empty
//   instr_ready           consumer accepts the head this cycle
//   redirect, redirect_addr  taken jump: flush and refetch from redirect_addr
//   halted                endop consumed; fetching stopped
module instr_fetch #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned INSTR_W = 17,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [4:0] ENDOP = 5'd31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               halted
);

  localparam int unsigned OPC_W = 5;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        vld_q, vld_d;
  entry_t            buf0_q, buf0_d;
  entry_t            buf1_q, buf1_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              stop_q, stop_d;
  logic              halted_q, halted_d;

  // FSM-derived controls
  logic run_c;
  logic start_go_c;

  // Datapath controls
  logic       pop_c;
  logic       endop_pop_c;
  logic       redir_c;
  logic       push_c;
  logic       issue_c;
  logic [1:0] count_c;
  logic [2:0] credit_c;
  entry_t     new_entry_c;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (endop_pop_c) state_d = HALT;
      HALT:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; start is ignored while running
  always_comb begin
    run_c      = 1'b0;
    start_go_c = 1'b0;
    case (state_q)
      IDLE:    start_go_c = start;
      RUN:     run_c = 1'b1;
      HALT:    start_go_c = start;
      default: ;
    endcase
  end

  // Handshake, squash and issue-credit decode
  always_comb begin
    pop_c       = vld_q[0] & instr_ready;
    endop_pop_c = run_c & pop_c & (buf0_q.instr[INSTR_W-1 -: OPC_W] == ENDOP);
    redir_c     = run_c & redirect;
    push_c      = run_c & inflight_q & ~redir_c & ~stop_q;
    count_c     = 2'(vld_q[0]) + 2'(vld_q[1]);
    // occupancy after this cycle's pop, counting the read already in flight
    credit_c    = 3'(count_c) + 3'(inflight_q) - 3'(pop_c);
    issue_c     = run_c & ~stop_q & ~redir_c & (credit_c < 3'd2);
    new_entry_c = '{instr: mem_data, pc: inflight_pc_q};
  end

  // Datapath next-state
  always_comb begin
    pc_d          = pc_q;
    vld_d         = vld_q;
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    stop_d        = stop_q;
    halted_d      = halted_q;

    if (start_go_c) begin
      pc_d       = START_ADDR;
      vld_d      = 2'b00;
      inflight_d = 1'b0;
      stop_d     = 1'b0;
      halted_d   = 1'b0;
    end else if (run_c) begin
      // shift on pop, then append the returning read at the new tail
      if (pop_c) begin
        buf0_d   = buf1_q;
        vld_d[0] = vld_q[1];
        vld_d[1] = 1'b0;
      end
      if (push_c) begin
        if (!vld_d[0]) begin
          buf0_d   = new_entry_c;
          vld_d[0] = 1'b1;
        end else begin
          buf1_d   = new_entry_c;
          vld_d[1] = 1'b1;
        end
        if (mem_data[INSTR_W-1 -: OPC_W] == ENDOP) stop_d = 1'b1;
      end

      if (redir_c) begin
        vld_d      = 2'b00;
        inflight_d = 1'b0;
        stop_d     = 1'b0;
        pc_d       = redirect_addr;
      end else begin
        inflight_d = issue_c;
        if (issue_c) begin
          pc_d          = pc_q + ADDR_W'(1);
          inflight_pc_d = pc_q;
        end
      end

      if (endop_pop_c) begin
        vld_d      = 2'b00;
        inflight_d = 1'b0;
        halted_d   = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= START_ADDR;
      vld_q         <= 2'b00;
      buf0_q        <= '0;
      buf1_q        <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      stop_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      vld_q         <= vld_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      stop_q        <= stop_d;
      halted_q      <= halted_d;
    end
  end

  assign mem_addr    = pc_q;
  assign instr       = buf0_q.instr;
  assign instr_pc    = buf0_q.pc;
  assign instr_valid = vld_q[0];
  assign halted      = halted_q;

endmodule
